// File: rtl/output_argmax.sv
// rtl/output_argmax.sv - argmax over the output layer's per-class ReLU scores
//
// Collects NUM_CLASSES scores as their individual strobes arrive. It then scans
// them one per cycle to find the maximum and presents the winning index and
// score on a valid/ready handshake.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   output_relu_out[i]    per-class score (unsigned)
//   output_relu_valid[i]  per-class capture strobe
//   class_idx/score       winning class index / score (held after acceptance)
//   class_valid/ready     result handshake
//   busy                  high while scanning or holding a result
//   overrun               sticky: a strobe arrived while not collecting

module output_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int IDX_WIDTH   = $clog2(NUM_CLASSES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] output_relu_out [0:NUM_CLASSES-1],
  input  logic [NUM_CLASSES-1:0] output_relu_valid,
  output logic [IDX_WIDTH-1:0]  class_idx,
  output logic [DATA_WIDTH-1:0] class_score,
  output logic                  class_valid,
  input  logic                  class_ready,
  output logic                  busy,
  output logic                  overrun
);

  typedef enum logic [1:0] {COLLECT, SCAN, DONE} state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

  state_t                 state;
  logic [DATA_WIDTH-1:0]  score_reg [0:NUM_CLASSES-1];
  logic [NUM_CLASSES-1:0] seen;
  logic [IDX_WIDTH-1:0]   ptr;
  logic [IDX_WIDTH-1:0]   best_idx;
  logic [DATA_WIDTH-1:0]  best;

  // Running-maximum update for the current scan position. The strict compare
  // keeps the lowest index on ties.
  logic [DATA_WIDTH-1:0]  cur_score;
  logic                   take;
  logic [DATA_WIDTH-1:0]  next_best;
  logic [IDX_WIDTH-1:0]   next_idx;

  assign cur_score = score_reg[ptr];
  assign take      = cur_score > best;
  assign next_best = take ? cur_score : best;
  assign next_idx  = take ? ptr : best_idx;

  assign busy = (state != COLLECT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= COLLECT;
      seen        <= '0;
      ptr         <= '0;
      best        <= '0;
      best_idx    <= '0;
      class_idx   <= '0;
      class_score <= '0;
      class_valid <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        score_reg[i] <= '0;
      end
    end else begin
      // Strobes outside COLLECT are dropped. This includes the acceptance edge.
      if (state != COLLECT && |output_relu_valid) begin
        overrun <= 1'b1;
      end

      case (state)
        COLLECT: begin
          for (int i = 0; i < NUM_CLASSES; i++) begin
            if (output_relu_valid[i]) begin
              score_reg[i] <= output_relu_out[i];
              seen[i]      <= 1'b1;
            end
          end
          // The completing edge also performs its own captures.
          if (&(seen | output_relu_valid)) begin
            state    <= SCAN;
            ptr      <= '0;
            best     <= '0;
            best_idx <= '0;
          end
        end

        SCAN: begin
          best     <= next_best;
          best_idx <= next_idx;
          ptr      <= ptr + IDX_WIDTH'(1);
          if (ptr == LAST_IDX) begin
            state       <= DONE;
            class_idx   <= next_idx;
            class_score <= next_best;
            class_valid <= 1'b1;
          end
        end

        DONE: begin
          if (class_valid && class_ready) begin
            class_valid <= 1'b0;
            seen        <= '0;
            state       <= COLLECT;
          end
        end

        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_output_argmax.sv
// tb/tb_output_argmax.sv - scoreboard bench for output_argmax

module tb_output_argmax;

  typedef logic [15:0] vec_t [0:9];

  logic        clk;
  logic        reset;
  logic [15:0] relu_out [0:9];
  logic [9:0]  relu_valid;
  logic [3:0]  class_idx;
  logic [15:0] class_score;
  logic        class_valid;
  logic        class_ready;
  logic        busy;
  logic        overrun;

  int tests = 0;
  int fails = 0;
  logic [19:0] exp_q [$];

  output_argmax dut (
    .clk(clk),
    .reset(reset),
    .output_relu_out(relu_out),
    .output_relu_valid(relu_valid),
    .class_idx(class_idx),
    .class_score(class_score),
    .class_valid(class_valid),
    .class_ready(class_ready),
    .busy(busy),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Monitor: compare every accepted result against the scoreboard.
  always @(negedge clk) begin
    if (reset && class_valid && class_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got idx %0d score 0x%0h, expected no result",
                 class_idx, class_score);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        check("result_idx", int'(class_idx), int'(e[19:16]));
        check("result_score", int'(class_score), int'(e[15:0]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Every task below starts and ends 1 time unit after a rising edge.
  task automatic capture_all(input vec_t s);
    relu_out   = s;
    relu_valid = '1;
    @(posedge clk); #1;
    relu_valid = '0;
  endtask

  // Called at the first sample after the completing edge. Requires ready high.
  task automatic wait_result(input string name);
    int lat;
    int busy_cnt;
    lat = -1;
    busy_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (busy) busy_cnt++;
      if (class_valid && lat < 0) lat = i;
      @(posedge clk); #1;
    end
    check({name, "_latency"}, lat, 10);
    check({name, "_busy_cycles"}, busy_cnt, 11);
  endtask

  initial begin
    vec_t v;
    int   ok;
    int   lat;

    reset       = 1'b0;
    relu_valid  = '0;
    class_ready = 1'b0;
    for (int i = 0; i < 10; i++) relu_out[i] = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Reset state
    check("rst_idx", int'(class_idx), 0);
    check("rst_score", int'(class_score), 0);
    check("rst_valid", int'(class_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);

    // Test 1: all strobes in one cycle, with a tie between index 2 and index 5
    class_ready = 1'b1;
    v = '{16'd5, 16'd3, 16'd9, 16'd1, 16'd0, 16'd9, 16'd2, 16'd8, 16'd7, 16'd4};
    exp_q.push_back({4'd2, 16'd9});
    capture_all(v);
    wait_result("t1");

    // Test 2: staggered strobes with index 9 last
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      relu_out[i]   = (i == 9) ? 16'hFFFF : 16'h0100;
      relu_valid    = '0;
      relu_valid[i] = 1'b1;
      if (i == 9) exp_q.push_back({4'd9, 16'hFFFF});
      @(posedge clk); #1;
      relu_valid = '0;
      if (i < 9 && busy) ok = 0;
    end
    check("t2_no_early_scan", ok, 1);
    wait_result("t2");

    // Test 3: index 4 strobed twice, and the latest value wins
    relu_out[4] = 16'h0050; relu_valid = 10'b00_0001_0000;
    @(posedge clk); #1;
    relu_out[4] = 16'h0010;
    @(posedge clk); #1;
    relu_valid = '0;
    check("t3_busy_partial", int'(busy), 0);
    for (int i = 0; i < 10; i++) if (i != 4) relu_out[i] = 16'h0020;
    relu_valid = 10'b11_1110_1111;
    exp_q.push_back({4'd0, 16'h0020});
    @(posedge clk); #1;
    relu_valid = '0;
    wait_result("t3");
    check("t3_overrun_clear", int'(overrun), 0);

    // Test 4: ready held low, and a strobe arrives during DONE
    class_ready = 1'b0;
    v = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10};
    capture_all(v);
    lat = -1;
    for (int i = 0; i < 15 && lat < 0; i++) begin
      if (class_valid) lat = i;
      else begin @(posedge clk); #1; end
    end
    check("t4_latency", lat, 10);
    ok = 1;
    for (int i = 0; i < 20; i++) begin
      if (!(class_valid && busy && class_idx == 4'd9 && class_score == 16'd10)) ok = 0;
      if (i == 5) begin relu_out[3] = 16'hAAAA; relu_valid = 10'b00_0000_1000; end
      else relu_valid = '0;
      @(posedge clk); #1;
    end
    relu_valid = '0;
    check("t4_outputs_stable", ok, 1);
    check("t4_overrun", int'(overrun), 1);
    exp_q.push_back({4'd9, 16'd10});
    class_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_valid_dropped", int'(class_valid), 0);
    check("t4_busy_after", int'(busy), 0);
    check("t4_idx_retained", int'(class_idx), 9);
    // seen must be cleared, so indices 0..8 alone must not complete a set
    for (int i = 0; i < 9; i++) relu_out[i] = 16'h0007;
    relu_valid = 10'b01_1111_1111;
    @(posedge clk); #1;
    relu_valid = '0;
    check("t4_seen_cleared", int'(busy), 0);
    relu_out[9] = 16'h0003; relu_valid = 10'b10_0000_0000;
    exp_q.push_back({4'd0, 16'h0007});
    @(posedge clk); #1;
    relu_valid = '0;
    wait_result("t4b");

    // Test 5: reset on the 5th SCAN edge discards the scan
    v = '{16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd50};
    capture_all(v);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("t5_idx_zero", int'(class_idx), 0);
    check("t5_score_zero", int'(class_score), 0);
    check("t5_valid_zero", int'(class_valid), 0);
    check("t5_busy_zero", int'(busy), 0);
    check("t5_overrun_zero", int'(overrun), 0);
    ok = 1;
    for (int i = 0; i < 15; i++) begin
      if (class_valid) ok = 0;
      @(posedge clk); #1;
    end
    check("t5_no_result", ok, 1);
    v = '{16'd100, 16'd200, 16'd300, 16'd50, 16'd300, 16'd0, 16'd0, 16'd0, 16'd0, 16'd299};
    exp_q.push_back({4'd2, 16'd300});
    capture_all(v);
    wait_result("t5b");

    // Test 6: all scores zero
    v = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    exp_q.push_back({4'd0, 16'd0});
    capture_all(v);
    wait_result("t6");

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/output_argmax.md
# output_argmax

Consumer of the output layer's per-neuron ReLU results: collects the 10 scores as their individual valid strobes arrive, sequentially scans them for the maximum, and presents the winning class index and score on a valid/ready handshake. Sits directly downstream of the output layer and is the final classification stage of the inference datapath.

## Interface
- NUM_CLASSES, 10, number of output neurons/scores
- DATA_WIDTH, 16, score width; unsigned (ReLU outputs are non-negative)
- IDX_WIDTH, $clog2(NUM_CLASSES) (4), width of class index
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous, active-low; reset==0 at a rising edge resets the block
- output_relu_out  input  [DATA_WIDTH-1:0] x [0:NUM_CLASSES-1]  per-class scores from the output layer
- output_relu_valid  input  NUM_CLASSES  per-class capture strobes, one bit per score, independent timing
- class_idx  output  IDX_WIDTH  index of maximum score
- class_score  output  DATA_WIDTH  maximum score value
- class_valid  output  1  result valid; held until accepted
- class_ready  input  1  downstream accepts result when high with class_valid
- busy  output  1  high whenever state != COLLECT
- overrun  output  1  sticky; a score strobe arrived while not collecting

## Operation
- State machine: COLLECT -> SCAN -> DONE -> COLLECT.
- COLLECT: for each i with output_relu_valid[i]=1, score_reg[i] <= output_relu_out[i], seen[i] <= 1. Repeat strobe for an already-seen i overwrites (latest value wins). Multiple bits may strobe in one cycle.
- Transition to SCAN at the edge where (seen | output_relu_valid) is all ones; that edge also performs the final captures. On entry: ptr <= 0, best <= 0, best_idx <= 0.
- SCAN: each cycle compare score_reg[ptr] > best (strict, unsigned); if true best <= score_reg[ptr], best_idx <= ptr. ptr increments by 1. At the edge processing ptr==NUM_CLASSES-1: state <= DONE, class_idx/class_score <= final best_idx/best (including that last comparison), class_valid <= 1.
- Ties: lowest index wins (strict >). All-zero scores -> class_idx=0, class_score=0.
- DONE: outputs held stable. At an edge with class_valid=1 and class_ready=1: class_valid <= 0, seen <= 0, state <= COLLECT. class_idx/class_score retain last value after acceptance.
- Strobes while in SCAN or DONE (including the acceptance edge) are dropped, not captured; overrun <= 1. overrun clears only on reset.
- busy is combinational from state.

## Timing
- Reset (reset==0 at edge): state=COLLECT, seen=0, score_reg=0, ptr=0, best=0, best_idx=0, class_idx=0, class_score=0, class_valid=0, overrun=0; busy=0. Reset wins over every other event, including mid-SCAN and mid-handshake; an in-progress scan is discarded.
- Latency: if the completing capture edge is E, SCAN occupies edges E+1..E+NUM_CLASSES; class_valid is high in the cycle after edge E+NUM_CLASSES (10 edges after E for defaults).
- class_ready may be high before class_valid; acceptance occurs on the first edge where both are high, minimum one DONE cycle visible.
- Earliest next capture: the cycle after the acceptance edge. Back-to-back throughput: one result per NUM_CLASSES+2 cycles minimum with all strobes in one cycle and ready held high.
- class_ready is ignored outside DONE.

## Test plan
- All 10 strobes in one cycle, scores 5,3,9,1,0,9,2,8,7,4, ready high -> class_valid rises exactly 10 edges after capture edge, class_idx=2, class_score=9 (tie with index 5 resolved low), busy high for 11 cycles.
- Strobes staggered one per cycle, index 9 last, score[9]=0xFFFF others 0x0100 -> SCAN starts only after index 9 edge, class_idx=9, class_score=0xFFFF.
- Index 4 strobed twice (0x0050 then 0x0010) before completion, others 0x0020 -> overwrite honored: class_idx=0, class_score=0x0020.
- class_ready held low 20 cycles after class_valid, strobe on index 3 during DONE -> outputs stable, strobe dropped, overrun=1; ready high -> class_valid drops next edge, busy=0, next collection starts with seen=0.
- reset==0 asserted on the 5th SCAN edge -> all outputs zero next cycle, no class_valid produced; fresh full strobe set afterwards yields correct result.
- All scores 0 -> class_idx=0, class_score=0, class_valid asserted at normal latency.
